// File: rtl/panel_input_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// panel_input_ctrl_pkg
// Shared constants and types for the front panel input stage.
//   page_e           display page select encoding (drives the display page mux)
//   DEFAULT_DEBOUNCE stable cycles needed before a debounced level changes
//   STEP_W           width of the CPU step counter
//   next_page()      page sequence PC -> RS -> RT -> ALU -> PC
// -----------------------------------------------------------------------------
package panel_input_ctrl_pkg;

    typedef enum logic [1:0] {
        PAGE_PC  = 2'b00,   // PC / NPC
        PAGE_RS  = 2'b01,   // rs
        PAGE_RT  = 2'b10,   // rt
        PAGE_ALU = 2'b11    // ALU result / data bus
    } page_e;

    localparam int DEFAULT_DEBOUNCE = 40000;
    localparam int DEFAULT_CNT_W    = 16;
    localparam int STEP_W           = 16;

    // Explicit table so the page can only ever move one step around the ring.
    function automatic page_e next_page(input page_e cur);
        case (cur)
            PAGE_PC:  return PAGE_RS;
            PAGE_RS:  return PAGE_RT;
            PAGE_RT:  return PAGE_ALU;
            default:  return PAGE_PC;
        endcase
    endfunction

endpackage

// File: rtl/panel_input_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a counting debounce filter for one raw
// push-button. The debounced level only changes after the synchronised input
// has differed from it for DEBOUNCE_CYCLES consecutive clk_base cycles; any
// shorter disagreement restarts the count.
// Ports:
//   clk_base  in   board clock
//   rst       in   synchronous reset, active-high
//   btn_raw   in   raw asynchronous button, active-high
//   level     out  debounced button level
//   rise      out  one-cycle pulse in the cycle level goes 0 -> 1
// -----------------------------------------------------------------------------
module btn_debounce
    import panel_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk_base,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             settle;

    assign differs = (sync_b != level);
    // This cycle completes a full run of disagreement: the level flips now.
    assign settle  = differs && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes the synchroniser a
    // real two-stage pipeline rather than a single wire.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            // NOTE: the synchroniser is cleared too, so a button still held
            // after reset must re-qualify through the whole filter.
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            rise   <= settle && sync_b;
            if (!differs) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/panel_input_ctrl.sv
// -----------------------------------------------------------------------------
// panel_input_ctrl
// Front panel stage: debounces the single-step and page buttons, produces the
// single-step CPU clock, counts steps and cycles the display page select.
// Ports:
//   clk_base    in   board clock, single domain
//   rst         in   synchronous reset, active-high
//   btn_step    in   raw single-step button
//   btn_page    in   raw page button
//   cpu_clk     out  debounced btn_step level; CPU clocks on its rising edge
//   step_pulse  out  one-cycle pulse per debounced btn_step press
//   step_count  out  steps since reset, wraps 16'hFFFF -> 16'h0000
//   page_type   out  display page select: 00 PC/NPC, 01 rs, 10 rt, 11 ALU/DB
// -----------------------------------------------------------------------------
module panel_input_ctrl
    import panel_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic              clk_base,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              btn_page,
    output logic              cpu_clk,
    output logic              step_pulse,
    output logic [STEP_W-1:0] step_count,
    output logic [1:0]        page_type
);

    logic              step_level;
    logic              step_rise;
    logic              unused_page_level;
    logic              page_rise;
    page_e             page_q;
    page_e             page_d;
    logic [STEP_W-1:0] step_count_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_step_db (
        .clk_base (clk_base),
        .rst      (rst),
        .btn_raw  (btn_step),
        .level    (step_level),
        .rise     (step_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_page_db (
        .clk_base (clk_base),
        .rst      (rst),
        .btn_raw  (btn_page),
        .level    (unused_page_level),
        .rise     (page_rise)
    );

    // Page select next state.
    always_comb begin
        // NOTE: hold value assigned first so no path leaves page_d unassigned
        // and no latch is inferred.
        page_d = page_q;
        if (page_rise) begin
            page_d = next_page(page_q);
        end
    end

    always_ff @(posedge clk_base) begin
        if (rst) begin
            page_q       <= PAGE_PC;
            step_count_q <= '0;
        end else begin
            page_q <= page_d;
            if (step_rise) begin
                step_count_q <= step_count_q + STEP_W'(1);
            end
        end
    end

    assign cpu_clk    = step_level;
    assign step_pulse = step_rise;
    assign step_count = step_count_q;
    assign page_type  = page_q;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_panel_input_ctrl
// Self-checking bench for panel_input_ctrl with DEBOUNCE_CYCLES=4.
// A directed vector table, hand-written multi-cycle sequences and a random
// phase compared against a history-based reference model.
// -----------------------------------------------------------------------------
module tb_panel_input_ctrl;

    localparam int D    = 4;
    localparam int HIST = D + 2;
    localparam int NV   = 25;

    logic        clk_base;
    logic        rst;
    logic        btn_step;
    logic        btn_page;
    logic        cpu_clk;
    logic        step_pulse;
    logic [15:0] step_count;
    logic [1:0]  page_type;

    int checks = 0;
    int errors = 0;

    panel_input_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk_base   (clk_base),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_page   (btn_page),
        .cpu_clk    (cpu_clk),
        .step_pulse (step_pulse),
        .step_count (step_count),
        .page_type  (page_type)
    );

    initial clk_base = 1'b0;
    always #5 clk_base = ~clk_base;

    // ---------------- reference model ----------------
    // raw_hist[b][j] is the raw level applied before the j-th most recent
    // edge (j=0 newest). The debouncer sees raw values two edges late, and a
    // level flips once the D samples it has seen most recently all disagree
    // with the current level.
    bit          raw_hist [2][HIST];
    bit          m_db     [2];
    bit          m_rise   [2];
    logic [15:0] m_count;
    logic [1:0]  m_page;

    task automatic model_edge(input logic r, input logic bs, input logic bp);
        bit raw [2];
        bit all_diff;
        raw[0] = bs;
        raw[1] = bp;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < HIST; j++) raw_hist[b][j] = 1'b0;
                m_db[b]   = 1'b0;
                m_rise[b] = 1'b0;
            end
            m_count = 16'h0000;
            m_page  = 2'b00;
        end else begin
            m_count = m_count + 16'(m_rise[0]);
            m_page  = m_page + 2'(m_rise[1]);
            for (int b = 0; b < 2; b++) begin
                for (int j = HIST - 1; j > 0; j--) raw_hist[b][j] = raw_hist[b][j-1];
                raw_hist[b][0] = raw[b];
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (raw_hist[b][j] == m_db[b]) all_diff = 1'b0;
                end
                m_rise[b] = 1'b0;
                if (all_diff) begin
                    m_db[b]   = ~m_db[b];
                    m_rise[b] = m_db[b];
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_cpu_clk"},    16'(cpu_clk),    16'(m_db[0]));
        check({tag, "_step_pulse"}, 16'(step_pulse), 16'(m_rise[0]));
        check({tag, "_step_count"}, step_count,      m_count);
        check({tag, "_type"},       16'(page_type),  16'(m_page));
    endtask

    // Apply inputs, take one edge, advance the model, settle 1 time unit.
    task automatic cycle(input logic r, input logic bs, input logic bp);
        rst      = r;
        btn_step = bs;
        btn_page = bp;
        @(posedge clk_base);
        model_edge(r, bs, bp);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    typedef struct packed {
        logic        r;
        logic        bs;
        logic        bp;
        logic        cpu;
        logic        pulse;
        logic [15:0] count;
        logic [1:0]  page;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic bs, input logic bp,
                                input logic cpu, input logic pulse,
                                input logic [15:0] count, input logic [1:0] page);
        vec_t v;
        v.r = r; v.bs = bs; v.bp = bp; v.cpu = cpu; v.pulse = pulse;
        v.count = count; v.page = page;
        return v;
    endfunction

    vec_t vecs [NV];

    initial begin
        logic       lv_s;
        logic       lv_p;
        int         rem_s;
        int         rem_p;
        logic       r;
        logic [1:0] wrap_exp [5];

        rst = 1'b1; btn_step = 1'b0; btn_page = 1'b0;

        // ---- directed table: reset with buttons held, release, short glitch
        for (int i = 0; i < NV; i++) begin
            if (i < 3)       vecs[i] = mk(1, 1, 1, 0, 0, 16'd0, 2'd0);
            else if (i < 8)  vecs[i] = mk(0, 1, 1, 0, 0, 16'd0, 2'd0);
            else if (i == 8) vecs[i] = mk(0, 1, 1, 1, 1, 16'd0, 2'd0);
            else if (i < 11) vecs[i] = mk(0, 1, 1, 1, 0, 16'd1, 2'd1);
            else if (i < 16) vecs[i] = mk(0, 0, 0, 1, 0, 16'd1, 2'd1);
            else if (i < 18) vecs[i] = mk(0, 0, 0, 0, 0, 16'd1, 2'd1);
            else if (i < 21) vecs[i] = mk(0, 1, 0, 0, 0, 16'd1, 2'd1);
            else             vecs[i] = mk(0, 0, 0, 0, 0, 16'd1, 2'd1);
        end
        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].r, vecs[i].bs, vecs[i].bp);
            check($sformatf("vec%0d_cpu_clk", i),    16'(cpu_clk),    16'(vecs[i].cpu));
            check($sformatf("vec%0d_step_pulse", i), 16'(step_pulse), 16'(vecs[i].pulse));
            check($sformatf("vec%0d_step_count", i), step_count,      vecs[i].count);
            check($sformatf("vec%0d_type", i),       16'(page_type),  16'(vecs[i].page));
        end

        // ---- bounce on page: 3 high / 1 low x5, then held high
        do_reset();
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b0, 1'b0, 1'b1);
                check("bounce_hold_type", 16'(page_type), 16'd0);
            end
            cycle(1'b0, 1'b0, 1'b0);
            check("bounce_gap_type", 16'(page_type), 16'd0);
        end
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("bounce_final_type", 16'(page_type), (k >= 7) ? 16'd1 : 16'd0);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);
        check("bounce_after_release_type", 16'(page_type), 16'd1);

        // ---- page wrap: 5 clean presses from reset
        wrap_exp[0] = 2'b01; wrap_exp[1] = 2'b10; wrap_exp[2] = 2'b11;
        wrap_exp[3] = 2'b00; wrap_exp[4] = 2'b01;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1);
            check($sformatf("page_wrap%0d_type", p), 16'(page_type), 16'(wrap_exp[p]));
            for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);
        end
        check("page_wrap_step_count", step_count, 16'd0);

        // ---- simultaneous step and page rise
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b0, 1'b1, 1'b1);
            check("sim_cpu_clk",    16'(cpu_clk),    (k >= 6) ? 16'd1 : 16'd0);
            check("sim_step_pulse", 16'(step_pulse), (k == 6) ? 16'd1 : 16'd0);
            check("sim_step_count", step_count,      (k >= 7) ? 16'd1 : 16'd0);
            check("sim_type",       16'(page_type),  (k >= 7) ? 16'd1 : 16'd0);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);

        // ---- reset coinciding with a pending step pulse, button still held
        do_reset();
        for (int k = 1; k <= 6; k++) cycle(1'b0, 1'b1, 1'b0);
        check("rstrise_pulse_before", 16'(step_pulse), 16'd1);
        cycle(1'b1, 1'b1, 1'b0);
        check("rstrise_count", step_count, 16'd0);
        check("rstrise_cpu_clk", 16'(cpu_clk), 16'd0);
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("held_after_rst_pulse", 16'(step_pulse), (k == 6) ? 16'd1 : 16'd0);
            check("held_after_rst_count", step_count,      (k == 7) ? 16'd1 : 16'd0);
        end
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 1'b0);
        check("no_autorepeat_count", step_count, 16'd1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);

        // ---- step counter wrap from a preloaded value
        do_reset();
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);
        force dut.step_count_q = 16'hFFFE;
        #1;
        release dut.step_count_q;
        m_count = 16'hFFFE;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                cycle(1'b0, 1'b1, 1'b0);
                check_model("wrap");
            end
            for (int k = 0; k < 8; k++) begin
                cycle(1'b0, 1'b0, 1'b0);
                check_model("wrap");
            end
        end
        check("wrap_final_count", step_count, 16'h0000);
        check("wrap_type_kept", 16'(page_type), 16'd1);

        // ---- randomized phase against the reference model
        do_reset();
        lv_s = 1'b0; lv_p = 1'b0; rem_s = 0; rem_p = 0;
        for (int n = 0; n < 4000; n++) begin
            if (rem_s <= 0) begin
                lv_s  = ~lv_s;
                rem_s = int'($urandom_range(1, 12));
            end
            if (rem_p <= 0) begin
                lv_p  = ~lv_p;
                rem_p = int'($urandom_range(1, 12));
            end
            r = ($urandom_range(0, 299) == 0);
            cycle(r, lv_s, lv_p);
            rem_s--;
            rem_p--;
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
